// File: rtl/packet_injector.sv
// packet_injector: mesh-node traffic source driving the router local port with Req/Gnt/Full,
// destinations round-robin over the 3x3 mesh skipping the node itself.
module packet_injector #(
   parameter logic [5:0] routerID    = 6'b000_000,
   parameter int         packetwidth = 26,
   parameter int         GAP         = 4,
   parameter int         NUM_PACKETS = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   en,
   input  logic                   DnStrFull,
   input  logic                   GntDnStr,
   output logic                   ReqDnStr,
   output logic [packetwidth-1:0] PacketOut,
   output logic [9:0]             SentCount,
   output logic                   Done
);
   localparam int GW = $clog2(GAP + 2);
   localparam logic [GW-1:0] gapLimit = GW'(GAP);
   localparam logic [9:0] lastCount = 10'(NUM_PACKETS);

   function automatic logic [5:0] stepDest(input logic [5:0] d);
      return d[2:0] == 3'd2 ? {d[5:3] == 3'd2 ? 3'd0 : d[5:3] + 3'd1, 3'd0} : {d[5:3], d[2:0] + 3'd1};
   endfunction

   function automatic logic [5:0] nextDest(input logic [5:0] d);
      return stepDest(d) == routerID ? stepDest(stepDest(d)) : stepDest(d);
   endfunction

   // the destination after the last mesh node is the first valid one
   localparam logic [5:0] firstDest = nextDest(6'b010_010);

   typedef enum logic {IDLE, REQ} state_t;
   state_t state;
   logic [9:0] packetID;
   logic [5:0] destID;
   logic [GW-1:0] gapCnt;

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state     <= IDLE;
         ReqDnStr  <= 1'b0;
         PacketOut <= '0;
         SentCount <= '0;
         Done      <= 1'b0;
         packetID  <= '0;
         destID    <= firstDest;
         gapCnt    <= '0;
      end else if (state == IDLE) begin
         if (en && !Done) begin
            if (gapCnt < gapLimit)
               gapCnt <= gapCnt + 1'b1;
            else if (!DnStrFull && !GntDnStr) begin
               PacketOut <= packetwidth'({1'b1, packetID, routerID, destID, packetID[2:0]});
               ReqDnStr  <= 1'b1;
               state     <= REQ;
            end
         end
      end else if (GntDnStr) begin
         ReqDnStr  <= 1'b0;
         SentCount <= SentCount + 10'd1;
         packetID  <= packetID + 10'd1;
         destID    <= nextDest(destID);
         gapCnt    <= '0;
         state     <= IDLE;
         if (NUM_PACKETS != 0 && SentCount + 10'd1 == lastCount)
            Done <= 1'b1;
      end
endmodule

// File: tb/tb_packet_injector.sv
// tb_packet_injector: two injector instances checked every cycle against a transaction-level model.
module tb_packet_injector;
   logic clk = 1'b0, reset = 1'b0;
   logic [1:0] en = '0, full = '0, gnt = '0;
   logic [1:0] req, done;
   logic [25:0] pkt[2];
   logic [9:0] cnt[2];
   int checks = 0, errors = 0;
   int age[2] = '{0, 0};
   bit rnd = 0;

   localparam logic [5:0] RID[2] = '{6'o00, 6'o22};
   localparam int GAPS[2] = '{0, 4};
   localparam int NPS[2] = '{3, 0};
   localparam logic [5:0] EXPA[3] = '{6'o01, 6'o02, 6'o10};
   localparam logic [5:0] EXPB[10] = '{6'o00, 6'o01, 6'o02, 6'o10, 6'o11, 6'o12, 6'o20, 6'o21, 6'o00, 6'o01};

   always #5 clk = ~clk;

   packet_injector #(.routerID(6'o00), .packetwidth(26), .GAP(0), .NUM_PACKETS(3)) u0 (
      .clk(clk), .reset(reset), .en(en[0]), .DnStrFull(full[0]), .GntDnStr(gnt[0]),
      .ReqDnStr(req[0]), .PacketOut(pkt[0]), .SentCount(cnt[0]), .Done(done[0]));
   packet_injector #(.routerID(6'o22), .packetwidth(26), .GAP(4), .NUM_PACKETS(0)) u1 (
      .clk(clk), .reset(reset), .en(en[1]), .DnStrFull(full[1]), .GntDnStr(gnt[1]),
      .ReqDnStr(req[1]), .PacketOut(pkt[1]), .SentCount(cnt[1]), .Done(done[1]));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // mesh index i -> node {X,Y}, walked row by row
   function automatic logic [5:0] meshId(input int i);
      return {3'(i / 3), 3'(i % 3)};
   endfunction

   function automatic int nextIdx(input int i, input int k);
      int j = (i + 1) % 9;
      if (meshId(j) == RID[k]) j = (j + 1) % 9;
      return j;
   endfunction

   bit mReq[2], mDone[2];
   logic [25:0] mPkt[2];
   int mSent[2], mPid[2], mDest[2], mIdle[2];

   always @(posedge clk or negedge reset)
      if (!reset) begin
         for (int k = 0; k < 2; k++) begin
            mReq[k] <= 0; mDone[k] <= 0; mPkt[k] <= '0; mSent[k] <= 0;
            mPid[k] <= 0; mDest[k] <= nextIdx(8, k); mIdle[k] <= 0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (!mReq[k]) begin
               if (en[k] && !mDone[k]) begin
                  if (mIdle[k] < GAPS[k]) mIdle[k] <= mIdle[k] + 1;
                  else if (!full[k] && !gnt[k]) begin
                     mReq[k] <= 1;
                     mPkt[k] <= {1'b1, 10'(mPid[k]), RID[k], meshId(mDest[k]), 3'(mPid[k] % 8)};
                  end
               end
            end else if (gnt[k]) begin
               mReq[k] <= 0;
               mSent[k] <= (mSent[k] + 1) % 1024;
               mPid[k] <= (mPid[k] + 1) % 1024;
               mDest[k] <= nextIdx(mDest[k], k);
               mIdle[k] <= 0;
               if (NPS[k] != 0 && mSent[k] + 1 == NPS[k]) mDone[k] <= 1;
            end
         end
      end

   always @(negedge clk)
      if (reset)
         for (int k = 0; k < 2; k++) begin
            chk($sformatf("req%0d", k), 32'(req[k]), 32'(mReq[k]));
            chk($sformatf("pkt%0d", k), 32'(pkt[k]), 32'(mPkt[k]));
            chk($sformatf("cnt%0d", k), 32'(cnt[k]), 32'(mSent[k]));
            chk($sformatf("done%0d", k), 32'(done[k]), 32'(mDone[k]));
         end

   // sink: directed mode grants on the second cycle Req is seen, random mode adds
   // random delays, spurious idle grants, full bursts and enable drops
   task automatic drive();
      for (int k = 0; k < 2; k++) begin
         age[k] = req[k] ? age[k] + 1 : 0;
         if (!rnd) begin
            en[k] = 1'b1; full[k] = 1'b0; gnt[k] = (age[k] == 2);
         end else begin
            en[k] = ($urandom % 8) != 0;
            if ($urandom % 6 == 0) full[k] = ~full[k];
            gnt[k] = req[k] ? ($urandom % 3 == 0) : ($urandom % 10 == 0);
         end
      end
   endtask

   initial begin
      logic [25:0] qa[$], qb[$];
      int ra[$], rb[$];
      int firstA = -1;
      logic [1:0] prevReq = '0;
      repeat (3) @(negedge clk);
      chk("rst_req", 32'(req), 0);
      chk("rst_pkt0", 32'(pkt[0]), 0);
      chk("rst_cnt0", 32'(cnt[0]), 0);
      chk("rst_done", 32'(done), 0);
      reset = 1'b1;
      drive();
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         if (req[0] && firstA < 0) firstA = i;
         drive();
      end
      chk("a_first_req_edge", 32'(firstA), 1);
      chk("a_req_before_rst", 32'(req[0]), 1);
      chk("a_cnt_before_rst", 32'(cnt[0]), 1);
      #2 reset = 1'b0;
      #1;
      chk("midreq_rst_req", 32'(req[0]), 0);
      chk("midreq_rst_pkt", 32'(pkt[0]), 0);
      chk("midreq_rst_cnt", 32'(cnt[0]), 0);
      gnt = '0; age = '{0, 0};
      repeat (2) @(negedge clk);
      reset = 1'b1;
      drive();
      for (int i = 1; i <= 80; i++) begin
         @(negedge clk);
         if (req[0] && !prevReq[0]) ra.push_back(i);
         if (req[1] && !prevReq[1]) rb.push_back(i);
         prevReq = req;
         drive();
         if (gnt[0] && req[0]) qa.push_back(pkt[0]);
         if (gnt[1] && req[1]) qb.push_back(pkt[1]);
      end
      chk("a_req_rises", 32'(ra.size()), 3);
      chk("b_min_rises", 32'(rb.size() >= 10), 1);
      if (ra.size() == 3) begin
         chk("a_first_req_edge2", 32'(ra[0]), 1);
         chk("a_period1", 32'(ra[1] - ra[0]), 3);
         chk("a_period2", 32'(ra[2] - ra[1]), 3);
      end
      if (rb.size() >= 2) begin
         chk("b_first_req_edge", 32'(rb[0]), 5);
         chk("b_period", 32'(rb[1] - rb[0]), 7);
      end
      chk("a_npkts", 32'(qa.size()), 3);
      for (int j = 0; j < qa.size() && j < 3; j++) begin
         chk($sformatf("a_dest%0d", j), 32'(qa[j][8:3]), 32'(EXPA[j]));
         chk($sformatf("a_pid%0d", j), 32'(qa[j][24:15]), j);
      end
      chk("a_done", 32'(done[0]), 1);
      chk("a_cnt", 32'(cnt[0]), 3);
      chk("a_req_after_done", 32'(req[0]), 0);
      chk("b_npkts", 32'(qb.size() >= 10), 1);
      for (int j = 0; j < qb.size() && j < 10; j++) begin
         chk($sformatf("b_dest%0d", j), 32'(qb[j][8:3]), 32'(EXPB[j]));
         chk($sformatf("b_sender%0d", j), 32'(qb[j][14:9]), 32'h12);
         chk($sformatf("b_payload%0d", j), 32'(qb[j][2:0]), 32'(j % 8));
         chk($sformatf("b_valid%0d", j), 32'(qb[j][25]), 1);
      end
      rnd = 1;
      repeat (3000) begin
         @(negedge clk);
         drive();
      end
      chk("a_req_stays_low", 32'(req[0]), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
